// File: rtl/systolic_feeder_pkg.sv
//------------------------------------------------------------------------------
// Module   : systolic_feeder_pkg
// Purpose  : Shared sizes, state encoding and lane helpers for the feeder.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package systolic_feeder_pkg;

  localparam int c_N_DEF  = 3;
  localparam int c_DW_DEF = 8;

  function automatic int load_len(input int n);
    return 2 * n * n;
  endfunction

  function automatic int feed_len(input int n);
    return 3 * n - 2;
  endfunction

  localparam int c_LOAD_LEN_DEF = 2 * c_N_DEF * c_N_DEF;
  localparam int c_FEED_LEN_DEF = 3 * c_N_DEF - 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_FEED  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Bit offset of lane/element idx inside a flat vector of width-bit items.
  function automatic int lane_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/systolic_skew_lane.sv
//------------------------------------------------------------------------------
// Module   : systolic_skew_lane
// Purpose  : Picks element (t - LANE) of one row/column, or zero outside window.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module systolic_skew_lane
  import systolic_feeder_pkg::*;
#(
  parameter int N         = c_N_DEF,
  parameter int data_size = c_DW_DEF,
  parameter int TW        = 3,
  parameter int LANE      = 0
) (
  input  logic [TW-1:0]          t,
  input  logic [N*data_size-1:0] vec,
  output logic [data_size-1:0]   elem
);

  always_comb begin
    elem = '0;
    for (int k = 0; k < N; k++) begin
      if (t == TW'(LANE + k)) begin
        elem = vec[lane_lsb(k, data_size) +: data_size];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/systolic_feeder.sv
//------------------------------------------------------------------------------
// Module   : systolic_feeder
// Purpose  : Loads A and B, clears the array, then streams skewed rows/columns.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int N         = c_N_DEF,
  parameter int data_size = c_DW_DEF,
  parameter int LOAD_LEN  = load_len(N),
  parameter int FEED_LEN  = feed_len(N)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [data_size-1:0]   ld_data,
  output logic [N*data_size-1:0] a_arr,
  output logic [N*data_size-1:0] b_arr,
  output logic                   arr_clr,
  output logic                   busy,
  output logic                   done
);

  localparam int c_LCW = (LOAD_LEN > 1) ? $clog2(LOAD_LEN) : 1;
  localparam int c_TW  = (FEED_LEN > 1) ? $clog2(FEED_LEN) : 1;

  state_t                     r_state;
  logic [c_LCW-1:0]           r_ld_cnt;
  logic [c_TW-1:0]            r_t;
  logic [data_size-1:0]       r_mem [LOAD_LEN];

  logic                       w_beat;
  logic [c_TW-1:0]            w_t_next;
  logic [N*N*data_size-1:0]   w_a_rows;
  logic [N*N*data_size-1:0]   w_b_cols;
  logic [N*data_size-1:0]     w_a_next;
  logic [N*data_size-1:0]     w_b_next;

  assign w_beat = ld_valid & ld_ready;

  // Output registers hold the lanes for the feed index about to be presented.
  always_comb begin
    w_t_next = r_t + 1'b1;
    if (r_state == ST_CLEAR) begin
      w_t_next = '0;
    end
  end

  generate
    for (genvar i = 0; i < N; i++) begin : g_lane
      for (genvar k = 0; k < N; k++) begin : g_elem
        assign w_a_rows[lane_lsb(i * N + k, data_size) +: data_size] = r_mem[i * N + k];
        assign w_b_cols[lane_lsb(i * N + k, data_size) +: data_size] = r_mem[N * N + k * N + i];
      end

      systolic_skew_lane #(
        .N(N), .data_size(data_size), .TW(c_TW), .LANE(i)
      ) u_skew_a (
        .t   (w_t_next),
        .vec (w_a_rows[lane_lsb(i * N, data_size) +: N * data_size]),
        .elem(w_a_next[lane_lsb(i, data_size) +: data_size])
      );

      systolic_skew_lane #(
        .N(N), .data_size(data_size), .TW(c_TW), .LANE(i)
      ) u_skew_b (
        .t   (w_t_next),
        .vec (w_b_cols[lane_lsb(i * N, data_size) +: N * data_size]),
        .elem(w_b_next[lane_lsb(i, data_size) +: data_size])
      );
    end
  endgenerate

  // Operand storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!reset && r_state == ST_IDLE && w_beat) begin
      r_mem[r_ld_cnt] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_ld_cnt <= '0;
      r_t      <= '0;
      ld_ready <= 1'b0;
      a_arr    <= '0;
      b_arr    <= '0;
      arr_clr  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          ld_ready <= 1'b1;
          if (w_beat) begin
            if (r_ld_cnt == c_LCW'(LOAD_LEN - 1)) begin
              r_state  <= ST_CLEAR;
              r_ld_cnt <= '0;
              ld_ready <= 1'b0;
              arr_clr  <= 1'b1;
              busy     <= 1'b1;
            end else begin
              r_ld_cnt <= r_ld_cnt + 1'b1;
            end
          end
        end
        ST_CLEAR: begin
          r_state <= ST_FEED;
          arr_clr <= 1'b0;
          r_t     <= w_t_next;
          a_arr   <= w_a_next;
          b_arr   <= w_b_next;
        end
        ST_FEED: begin
          if (r_t == c_TW'(FEED_LEN - 1)) begin
            r_state <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            a_arr   <= '0;
            b_arr   <= '0;
          end else begin
            r_t   <= w_t_next;
            a_arr <= w_a_next;
            b_arr <= w_b_next;
          end
        end
        ST_DONE: begin
          r_state  <= ST_IDLE;
          done     <= 1'b0;
          ld_ready <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_systolic_feeder.sv
//------------------------------------------------------------------------------
// Module   : tb_systolic_feeder
// Purpose  : Self-checking bench for systolic_feeder driving a behavioural array.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_systolic_feeder;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int NN = N * N;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ld_valid = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_ready;
  logic [N*DW-1:0] a_arr;
  logic [N*DW-1:0] b_arr;
  logic          arr_clr;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  systolic_feeder #(.N(N), .data_size(DW)) dut (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .a_arr(a_arr), .b_arr(b_arr), .arr_clr(arr_clr),
    .busy(busy), .done(done)
  );

  // Output-stationary array the feeder is meant to drive.
  int pa[N][N], pb[N][N], acc[N][N], na[N][N], nb[N][N];
  always @(posedge clk) begin
    if (reset || arr_clr) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          pa[i][j] = 0; pb[i][j] = 0; acc[i][j] = 0;
        end
    end else begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          na[i][j] = (j == 0) ? int'(a_arr[i*DW +: DW]) : pa[i][j-1];
          nb[i][j] = (i == 0) ? int'(b_arr[j*DW +: DW]) : pb[i-1][j];
          acc[i][j] = acc[i][j] + na[i][j] * nb[i][j];
        end
      pa = na;
      pb = nb;
    end
  end

  typedef struct {
    int a[NN];
    int b[NN];
    int mode;    // 0: valid held, 1: 1,0,0 pattern, 2: random gaps
    bit feedhi;  // keep ld_valid high through CLEAR/FEED
    int c[NN];
  } job_t;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void matmul(input int a[NN], input int b[NN], output int c[NN]);
    for (int r = 0; r < N; r++)
      for (int q = 0; q < N; q++) begin
        c[r*N+q] = 0;
        for (int k = 0; k < N; k++) c[r*N+q] += a[r*N+k] * b[k*N+q];
      end
  endfunction

  function automatic logic [N*DW-1:0] exp_a(input int a[NN], input int t);
    logic [N*DW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++)
      if (t - i >= 0 && t - i < N) v[i*DW +: DW] = DW'(a[i*N + t - i]);
    return v;
  endfunction

  function automatic logic [N*DW-1:0] exp_b(input int b[NN], input int t);
    logic [N*DW-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++)
      if (t - j >= 0 && t - j < N) v[j*DW +: DW] = DW'(b[(t - j)*N + j]);
    return v;
  endfunction

  // rst_at >= 0 asserts reset for one cycle at that feed index and stops the job.
  task automatic run_job(input job_t j, input string tag, input bit skewchk, input int rst_at);
    int idx, cyc;
    bit v;
    logic [3:0] st_exp;
    logic [N*DW-1:0] ea, eb;
    idx = 0; cyc = 0;
    while (idx < 2*NN && cyc < 300) begin
      @(negedge clk);
      cyc++;
      case (j.mode)
        0: v = 1'b1;
        1: v = (cyc % 3 == 1);
        default: v = 1'($urandom_range(0, 1));
      endcase
      ld_valid = v;
      ld_data  = (idx < NN) ? DW'(j.a[idx]) : DW'(j.b[idx - NN]);
      if (v && ld_ready) idx++;
    end
    if (idx < 2*NN) begin
      total++; bad++;
      $display("FAIL %s_load_timeout: got %0d beats expected %0d", tag, idx, 2*NN);
      ld_valid = 1'b0;
      return;
    end
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      ld_valid = j.feedhi && c <= 8;
      ld_data  = 8'hEE;
      ea = '0; eb = '0;
      if (c == 1)       st_exp = 4'b0110;
      else if (c <= 8) begin
        st_exp = 4'b0010;
        ea = exp_a(j.a, c - 2);
        eb = exp_b(j.b, c - 2);
      end
      else if (c == 9)  st_exp = 4'b0001;
      else              st_exp = 4'b1000;
      chk($sformatf("%s_ctl_c%0d", tag, c), {ld_ready, arr_clr, busy, done}, st_exp);
      chk($sformatf("%s_a_c%0d", tag, c), a_arr, ea);
      chk($sformatf("%s_b_c%0d", tag, c), b_arr, eb);
      if (skewchk && c == 2) chk($sformatf("%s_skew_t0", tag), a_arr, 24'h000001);
      if (skewchk && c == 4) chk($sformatf("%s_skew_t2", tag), a_arr, 24'h070503);
      if (skewchk && c == 8) chk($sformatf("%s_skew_t6", tag), {a_arr, b_arr}, 48'h0);
      if (rst_at >= 0 && c == rst_at + 2) begin
        reset = 1'b1;
        @(negedge clk);
        chk($sformatf("%s_rst_ctl", tag), {ld_ready, arr_clr, busy, done}, 4'b0000);
        chk($sformatf("%s_rst_ab", tag), {a_arr, b_arr}, 48'h0);
        reset = 1'b0;
        @(negedge clk);
        chk($sformatf("%s_rst_idle", tag), {ld_ready, arr_clr, busy, done, a_arr, b_arr}, {4'b1000, 48'h0});
        return;
      end
    end
    for (int e = 0; e < NN; e++)
      chk($sformatf("%s_C%0d%0d", tag, e / N, e % N), acc[e / N][e % N], j.c[e]);
  endtask

  job_t jobs[6];
  job_t rj;

  initial begin
    jobs[0].a = '{1,0,0, 0,1,0, 0,0,1};
    jobs[0].b = '{1,2,3, 4,5,6, 7,8,9};
    jobs[0].mode = 0; jobs[0].feedhi = 0;
    jobs[0].c = '{1,2,3, 4,5,6, 7,8,9};

    jobs[1].a = '{1,2,3, 4,5,6, 7,8,9};
    jobs[1].b = '{9,8,7, 6,5,4, 3,2,1};
    jobs[1].mode = 0; jobs[1].feedhi = 0;
    jobs[1].c = '{30,24,18, 84,69,54, 138,114,90};

    jobs[2].a = '{2,2,2, 2,2,2, 2,2,2};
    jobs[2].b = '{3,3,3, 3,3,3, 3,3,3};
    jobs[2].mode = 0; jobs[2].feedhi = 0;
    jobs[2].c = '{18,18,18, 18,18,18, 18,18,18};

    jobs[3].a = '{1,0,0, 0,1,0, 0,0,1};
    jobs[3].b = '{1,0,0, 0,1,0, 0,0,1};
    jobs[3].mode = 0; jobs[3].feedhi = 0;
    jobs[3].c = '{1,0,0, 0,1,0, 0,0,1};

    jobs[4].a = '{5,0,7, 1,9,2, 250,3,4};
    jobs[4].b = '{1,2,0, 0,3,4, 6,0,1};
    jobs[4].mode = 1; jobs[4].feedhi = 1;
    matmul(jobs[4].a, jobs[4].b, jobs[4].c);

    jobs[5].a = '{100,100,100, 100,100,100, 100,100,100};
    jobs[5].b = '{100,100,100, 100,100,100, 100,100,100};
    jobs[5].mode = 0; jobs[5].feedhi = 0;
    jobs[5].c = '{30000,30000,30000, 30000,30000,30000, 30000,30000,30000};

    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ctl", {ld_ready, arr_clr, busy, done}, 4'b0000);
    chk("reset_ab", {a_arr, b_arr}, 48'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ready", {ld_ready, arr_clr, busy, done}, 4'b1000);

    for (int k = 0; k < 6; k++)
      run_job(jobs[k], $sformatf("job%0d", k), k == 1, -1);

    run_job(jobs[2], "rstfeed", 1'b0, 3);
    run_job(jobs[1], "after_rst", 1'b0, -1);

    for (int r = 0; r < 6; r++) begin
      for (int e = 0; e < NN; e++) begin
        rj.a[e] = int'($urandom_range(0, 255));
        rj.b[e] = int'($urandom_range(0, 255));
      end
      rj.mode = 2;
      rj.feedhi = 1'($urandom_range(0, 1));
      matmul(rj.a, rj.b, rj.c);
      run_job(rj, $sformatf("rand%0d", r), 1'b0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
Source side of the NxN output-stationary systolic multiplier. It accepts matrices A and B as a word stream, clears the array, then drives the skewed row stream on a_arr and the skewed column stream on b_arr. It pulses done on the cycle after the last product has been accumulated. Its outputs connect directly to the array's a_arr, b_arr and reset inputs.

Parameters:
N, 3, array dimension (matrices are NxN)
data_size, 8, bits per matrix element
LOAD_LEN, 2*N*N, beats per job (derived, do not override)
FEED_LEN, 3*N-2, feed cycles per job (derived, do not override)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
ld_valid  input  1  load beat valid
ld_ready  output  1  feeder can accept a beat
ld_data  input  data_size  element value
a_arr  output  N*data_size  row stream; lane i is bits [i*data_size +: data_size]
b_arr  output  N*data_size  column stream; lane j is bits [j*data_size +: data_size]
arr_clr  output  1  clears the array accumulators and pipeline registers
busy  output  1  a job is in CLEAR or FEED
done  output  1  one-cycle pulse: array results are final

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values: ld_ready=0, a_arr=0, b_arr=0, arr_clr=0, busy=0, done=0. State goes to IDLE and the load counter to 0. The array shares reset, so the feeder does not assert arr_clr during reset.
- States: IDLE -> CLEAR -> FEED -> DONE -> IDLE.
- IDLE:
  - ld_ready=1.
  - A beat transfers on a cycle with ld_valid & ld_ready.
  - Beat order: beats 0..N*N-1 are A, row-major (A[r][c] at beat r*N+c). Beats N*N..2*N*N-1 are B, row-major.
  - Gaps in ld_valid are allowed; the counter holds during gaps.
  - The cycle after beat LOAD_LEN-1 transfers, the state is CLEAR.
- CLEAR: one cycle. arr_clr=1, ld_ready=0, busy=1. a_arr and b_arr are 0.
- FEED: FEED_LEN cycles, feed index t=0..3N-3. busy=1, ld_ready=0, ld_valid ignored. In cycle t:
  - a_arr lane i = A[i][t-i] if 0<=t-i<N, else 0.
  - b_arr lane j = B[t-j][j] if 0<=t-j<N, else 0.
- Timing consequence: PE(i,j) accumulates A[i][k]*B[k][j] at the edge ending cycle k+i+j. The last product lands at the edge ending t=3N-3.
- DONE: one cycle. done=1, busy=0, a_arr=b_arr=0. The next state is IDLE with the load counter at 0.
- Between jobs, arr_clr stays 0 in IDLE, so the array holds its results until the next CLEAR.
- Job latency: last load beat to done is 1 + FEED_LEN + 1 cycles (N=3: 9 cycles).
- Zeros outside the skew window are mandatory. Stale values would corrupt the accumulators.
- Reset mid-LOAD or mid-FEED: on the next edge all outputs return to their reset values and partially loaded data is discarded. A new job starts from beat 0.
- Storage: 2*N*N registers of data_size bits, written only in IDLE. Contents are not cleared by reset (don't-care until overwritten).
- No arithmetic is performed. Counters are sized by $clog2(LOAD_LEN) and $clog2(FEED_LEN).

Decomposition:
- Shared package holds:
  - N and data_size defaults.
  - LOAD_LEN and FEED_LEN.
  - The state encoding IDLE/CLEAR/FEED/DONE.
  - Lane slice helpers.
- One natural sub-module: systolic_skew_lane. It takes lane index, feed index t and one matrix row (or column) of N elements, and outputs the element or 0. It is instantiated N times for A and N times for B.

Test Plan:
- Identity: N=3, A=I, B=[[1,2,3],[4,5,6],[7,8,9]], ld_valid held high. Expect 18 transfers, one arr_clr cycle, 7 feed cycles, and done 9 cycles after the last beat. Array outputs must equal B.
- Skew check: A=[[1,2,3],[4,5,6],[7,8,9]]. In feed cycle t=2, expect a_arr lanes = {3,5,7}. In t=0, expect lanes {1,0,0}. In t=6, expect all zero.
- Full product: A all 2, B all 3. Every array output must equal 18. Then run a second job with A=I and B=I: the outputs must be the identity matrix, which proves CLEAR wipes the previous job.
- Backpressure on load: ld_valid toggled 1,0,0,1,... over 18 beats. Expect correct element ordering and no extra beat accepted. ld_valid held high during FEED must not advance the counter.
- Reset mid-FEED: reset asserted at t=3 for one cycle. The next cycle must show all outputs 0, ld_ready=1 and state IDLE. Then reload 18 beats and get a correct result.
- Max operands: A and B elements all 100. Expect every array output = 30000 and done asserted for exactly one cycle.
